// File: rtl/var_delay_tap_reader_pkg.sv
// Shared types for the programmable tap delay line.
package var_delay_tap_reader_pkg;

  // FILL: buffer not yet primed for the latched depth.
  // RUN:  each enabled edge presents a real delayed sample.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/var_delay_tap_reader_ram.sv
// Simple dual-port RAM: one synchronous write port and one read port.
// The read is combinational from the array, so a read and a write to the
// same address on the same edge return the old contents.
module sdp_ram_sync #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port. Contents are never cleared; the fill counter masks stale data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/var_delay_tap_reader.sv
// Run-time programmable delay line built on a circular buffer.
// Behaves like an enable-gated shift register of depth D = i_delay+1, with a
// fill FSM that suppresses output until D samples have been written.
module var_delay_tap_reader
  import var_delay_tap_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_shift_en,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic [ADDR_WIDTH-1:0] i_delay,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_valid,
  output logic                  o_filling
);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_n;
  logic [ADDR_WIDTH:0]   fill_cnt, fill_cnt_n;
  logic [ADDR_WIDTH:0]   d_l, d_l_n;
  logic [DATA_WIDTH-1:0] out_n;
  logic                  valid_n;

  logic [ADDR_WIDTH:0]   d_req;
  logic [ADDR_WIDTH:0]   d_m1;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] tap;
  logic                  we;

  // Depth is one more than the select so a select of 0 means "no extra delay".
  assign d_req   = {1'b0, i_delay} + (ADDR_WIDTH+1)'(1);
  assign d_m1    = d_l - (ADDR_WIDTH+1)'(1);
  // Natural overflow of the subtraction gives the modulo-depth wrap; at full
  // depth this lands on wr_ptr+1, the oldest entry.
  assign rd_addr = wr_ptr - d_m1[ADDR_WIDTH-1:0];
  // Depth 1 has nothing stored yet for this sample, so bypass the buffer.
  assign tap     = (d_l == (ADDR_WIDTH+1)'(1)) ? i_data_in : rd_data;
  assign we      = i_shift_en && !i_rst;
  assign o_filling = (state == ST_FILL);

  sdp_ram_sync #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (i_clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (i_data_in),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Next-state: delay change restarts the fill, otherwise advance on enables.
  always_comb begin
    state_n    = state;
    wr_ptr_n   = wr_ptr;
    fill_cnt_n = fill_cnt;
    d_l_n      = d_l;
    out_n      = o_data_out;
    valid_n    = o_data_valid;
    if (i_shift_en) wr_ptr_n = wr_ptr + ADDR_WIDTH'(1);
    if (d_req != d_l) begin
      // The write on this edge still counts toward the new fill.
      d_l_n      = d_req;
      state_n    = ST_FILL;
      fill_cnt_n = i_shift_en ? (ADDR_WIDTH+1)'(1) : '0;
      out_n      = '0;
      valid_n    = 1'b0;
    end else if (i_shift_en) begin
      case (state)
        ST_FILL: begin
          // >= also covers a fill count already at depth after a change to D=1.
          if (fill_cnt >= d_m1) begin
            state_n    = ST_RUN;
            fill_cnt_n = d_l;
            out_n      = tap;
            valid_n    = 1'b1;
          end else begin
            fill_cnt_n = fill_cnt + (ADDR_WIDTH+1)'(1);
          end
        end
        default: begin
          out_n   = tap;
          valid_n = 1'b1;
        end
      endcase
    end
  end

  // State register; reset samples the requested delay.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_FILL;
      wr_ptr       <= '0;
      fill_cnt     <= '0;
      d_l          <= d_req;
      o_data_out   <= '0;
      o_data_valid <= 1'b0;
    end else begin
      state        <= state_n;
      wr_ptr       <= wr_ptr_n;
      fill_cnt     <= fill_cnt_n;
      d_l          <= d_l_n;
      o_data_out   <= out_n;
      o_data_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_var_delay_tap_reader.sv
// Directed bench for var_delay_tap_reader: table of per-edge vectors plus a
// full-depth wrap sequence.
module tb_var_delay_tap_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] din;
  logic [3:0]  dly;
  logic [15:0] q;
  logic        v;
  logic        f;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  dly;
    logic [15:0] din;
    logic [15:0] q;
    logic        v;
    logic        f;
  } vec_t;

  vec_t tbl[$];

  var_delay_tap_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_shift_en   (en),
    .i_data_in    (din),
    .i_delay      (dly),
    .o_data_out   (q),
    .o_data_valid (v),
    .o_filling    (f)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic e, logic [3:0] d, logic [15:0] x,
                              logic [15:0] eq, logic ev, logic ef);
    vec_t t;
    t.rst = r; t.en = e; t.dly = d; t.din = x;
    t.q = eq; t.v = ev; t.f = ef;
    return t;
  endfunction

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic e, input logic [3:0] d, input logic [15:0] x);
    @(negedge clk);
    rst = r; en = e; dly = d; din = x;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] eq, input logic ev, input logic ef);
    checks++;
    if (q !== eq || v !== ev || f !== ef) begin
      failures++;
      $display("FAIL %s: got out=%h valid=%b filling=%b, want out=%h valid=%b filling=%b",
               name, q, v, f, eq, ev, ef);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dly = 4'd3; din = '0;

    // D=4 from reset, data 1,2,3...
    tbl.push_back(mk(1, 0, 3, 16'd0, 16'd0, 0, 1));
    tbl.push_back(mk(0, 1, 3, 16'd1, 16'd0, 0, 1));
    tbl.push_back(mk(0, 1, 3, 16'd2, 16'd0, 0, 1));
    tbl.push_back(mk(0, 1, 3, 16'd3, 16'd0, 0, 1));
    tbl.push_back(mk(0, 1, 3, 16'd4, 16'd1, 1, 0));
    tbl.push_back(mk(0, 1, 3, 16'd5, 16'd2, 1, 0));
    tbl.push_back(mk(0, 1, 3, 16'd6, 16'd3, 1, 0));
    // Gaps in the enable: outputs hold, sequence continues by enabled edge.
    tbl.push_back(mk(0, 0, 3, 16'd99, 16'd3, 1, 0));
    tbl.push_back(mk(0, 0, 3, 16'd98, 16'd3, 1, 0));
    tbl.push_back(mk(0, 1, 3, 16'd7, 16'd4, 1, 0));
    tbl.push_back(mk(0, 0, 3, 16'd97, 16'd4, 1, 0));
    tbl.push_back(mk(0, 1, 3, 16'd8, 16'd5, 1, 0));
    // Change to D=2 on an enabled edge carrying 100.
    tbl.push_back(mk(0, 1, 1, 16'd100, 16'd0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 16'd101, 16'd100, 1, 0));
    tbl.push_back(mk(0, 1, 1, 16'd102, 16'd101, 1, 0));
    // Reset mid-RUN: full refill needed, no pre-reset data.
    tbl.push_back(mk(1, 1, 1, 16'd55, 16'd0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 16'd201, 16'd0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 16'd202, 16'd201, 1, 0));
    tbl.push_back(mk(0, 1, 1, 16'd203, 16'd202, 1, 0));
    // D=1 bypass.
    tbl.push_back(mk(1, 0, 0, 16'd0, 16'd0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 16'hA5A5, 16'hA5A5, 1, 0));
    tbl.push_back(mk(0, 1, 0, 16'h5A5A, 16'h5A5A, 1, 0));
    tbl.push_back(mk(0, 0, 0, 16'h1111, 16'h5A5A, 1, 0));
    // Delay change on a disabled edge still restarts the fill.
    tbl.push_back(mk(0, 0, 2, 16'h2222, 16'd0, 0, 1));
    tbl.push_back(mk(0, 1, 2, 16'd10, 16'd0, 0, 1));
    tbl.push_back(mk(0, 1, 2, 16'd11, 16'd0, 0, 1));
    tbl.push_back(mk(0, 1, 2, 16'd12, 16'd10, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].dly, tbl[i].din);
      check($sformatf("vec%0d", i), tbl[i].q, tbl[i].v, tbl[i].f);
    end

    // D=16: 40 samples 0..39, outputs 0..24 across both pointer wraps.
    step(1, 0, 4'd15, 16'd0);
    check("d16_reset", 16'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      step(0, 1, 4'd15, 16'(k - 1));
      if (k >= 16) check($sformatf("d16_edge%0d", k), 16'(k - 16), 1'b1, 1'b0);
      else         check($sformatf("d16_edge%0d", k), 16'd0, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
